// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sequencing controller:
// command codes, FSM states and flag bit positions.
package alu_share_ctrl_pkg;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned FLAG_W = 3;

  // Flag vector layout: {carryout, overflow, zero}
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_ZERO  = 0;

  typedef enum logic [CMD_W-1:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Assemble the ALU status bits into the response flag layout.
  function automatic logic [FLAG_W-1:0] pack_flags(input logic carryout,
                                                   input logic overflow,
                                                   input logic zero);
    logic [FLAG_W-1:0] f;
    f             = '0;
    f[FLAG_CARRY] = carryout;
    f[FLAG_OVF]   = overflow;
    f[FLAG_ZERO]  = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on contention the
// requester that was not granted last wins.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt_valid_c,
  output logic gnt_owner_c
);

  always_comb begin
    gnt_valid_c = valid0 | valid1;
    if (valid0 && valid1) begin
      gnt_owner_c = ~last_grant;
    end else begin
      gnt_owner_c = valid1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: arbitrate, register
// operands, capture result/flags one cycle later, hold until accepted.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [CMD_W-1:0]   req0_cmd,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [CMD_W-1:0]   req1_cmd,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,

  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic [WIDTH-1:0]   resp0_result,
  output logic [FLAG_W-1:0]  resp0_flags,

  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [WIDTH-1:0]   resp1_result,
  output logic [FLAG_W-1:0]  resp1_flags,

  output logic [CMD_W-1:0]   alu_cmd,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero
);

  state_e              state_q;
  state_e              state_d;
  logic                owner_q;
  logic                last_grant_q;
  logic                gnt_valid_c;
  logic                gnt_owner_c;
  logic                accept_c;
  logic                capture_c;
  logic                release_c;
  logic [FLAG_W-1:0]   flags_c;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_owner_c (gnt_owner_c)
  );

  assign flags_c = pack_flags(alu_carryout, alu_overflow, alu_zero);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; ready is only ever offered in IDLE
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept_c   = 1'b0;
    capture_c  = 1'b0;
    release_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          req0_ready = ~gnt_owner_c;
          req1_ready = gnt_owner_c;
          accept_c   = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture_c = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if ((!owner_q && resp0_ready) || (owner_q && resp1_ready)) begin
          release_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Owner tracking and round-robin pointer; pointer starts at 1 so req0
  // wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept_c) begin
      owner_q      <= gnt_owner_c;
      last_grant_q <= gnt_owner_c;
    end
  end

  // ALU operand registers, loaded only on an accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_cmd <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else if (accept_c) begin
      if (gnt_owner_c) begin
        alu_cmd <= req1_cmd;
        alu_a   <= req1_a;
        alu_b   <= req1_b;
      end else begin
        alu_cmd <= req0_cmd;
        alu_a   <= req0_a;
        alu_b   <= req0_b;
      end
    end
  end

  // Response channel 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp0_valid  <= 1'b0;
      resp0_result <= '0;
      resp0_flags  <= '0;
    end else if (capture_c && !owner_q) begin
      resp0_valid  <= 1'b1;
      resp0_result <= alu_result;
      resp0_flags  <= flags_c;
    end else if (release_c && !owner_q) begin
      resp0_valid  <= 1'b0;
    end
  end

  // Response channel 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp1_valid  <= 1'b0;
      resp1_result <= '0;
      resp1_flags  <= '0;
    end else if (capture_c && owner_q) begin
      resp1_valid  <= 1'b1;
      resp1_result <= alu_result;
      resp1_flags  <= flags_c;
    end else if (release_c && owner_q) begin
      resp1_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing controller that shares a single combinational ALU (the 3-bit-command ALU with its command decode LUT) between two independent requesters. Each requester issues an operation over a valid/ready request channel and gets the result back on its own valid/ready response channel. The block arbitrates round-robin, registers the operands into the ALU, captures the result and flags, and holds them until the owning requester accepts them. It sits between the two client blocks (e.g. address-calc and execute stages) and the ALU instance.

## Interface
- WIDTH, 32, operand/result width in bits
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle
- req0_cmd / req1_cmd  input  3  ALU command: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands
- resp0_valid / resp1_valid  output  1  result present
- resp0_ready / resp1_ready  input  1  requester consumes result
- resp0_result / resp1_result  output  WIDTH  captured ALU result
- resp0_flags / resp1_flags  output  3  {carryout, overflow, zero}
- alu_cmd  output  3  registered command to ALU
- alu_a, alu_b  output  WIDTH  registered operands to ALU
- alu_result  input  WIDTH  ALU result (combinational from alu_*)
- alu_carryout, alu_overflow, alu_zero  input  1  ALU flags

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant computed from req0_valid, req1_valid and last_grant; reqN_ready = 1 only for the granted requester, only in IDLE. On handshake, latch cmd/a/b into alu_cmd/alu_a/alu_b, record owner, update last_grant := owner, go EXEC.
- Round-robin: only one valid -> grant it; both valid -> grant the one not equal to last_grant. last_grant resets to 1, so requester 0 wins the first contention.
- EXEC (exactly one cycle): ALU settles; on the closing edge capture alu_result and {alu_carryout, alu_overflow, alu_zero} into the owner's resp registers, set respN_valid, go RESP.
- RESP: respN_valid held with stable result/flags until respN_ready = 1; that edge clears respN_valid, returns to IDLE. The non-owner response channel stays 0.
- alu_cmd/alu_a/alu_b hold their last value outside IDLE-handshake edges; no re-drive.
- All 8 command codes are legal; no error path.
- resp_ready asserted while the respective resp_valid = 0 is ignored.

## Timing
- Reset values: reqN_ready 0, respN_valid 0, respN_result 0, respN_flags 0, alu_cmd 0, alu_a 0, alu_b 0, state IDLE, last_grant 1.
- Request accepted at edge N -> EXEC in cycle N+1 -> respN_valid high from cycle N+2.
- Best-case throughput: one operation per 3 cycles (accept, exec, resp with ready=1); next request accepted in cycle after response handshake.
- reqN_ready is combinational from state and req valids; requesters must not make req_valid depend on req_ready.
- Reset mid-operation (EXEC or RESP): in-flight operation dropped, all outputs to reset values immediately; no response ever issued for it.
- Requester deasserting valid before ready: no acceptance, no state change.

## Structure
- Shared package/header: ALU command constants (ADD..OR), FSM state encodings, flag bit positions {carryout=2, overflow=1, zero=0}.
- One sub-module: rr_arb2 (2-way round-robin grant from two valids plus last_grant pointer, combinational).
- ALU itself instantiated outside; this block only drives its inputs.

## Test plan
- After reset, req0 ADD a=5 b=7 -> req0_ready in same cycle, alu_a=5 alu_b=7 next cycle, resp0_valid two cycles after accept with resp0_result=12, resp0_flags=3'b000.
- Both valid from reset (req0 SUB 3-3, req1 OR 0xF0|0x0F) -> req0 granted first, resp0_result=0 flags zero=1; then req1 granted, resp1_result=0xFF.
- Both valid continuously for 4 ops -> grants alternate 0,1,0,1.
- resp0_ready held low 5 cycles -> resp0_valid and resp0_result stable, req1_ready stays 0 throughout; release -> req1 accepted next cycle.
- Reset pulse during EXEC -> every output 0 asynchronously, no resp_valid afterward, next request after reset handled normally.
- SLT a=0xFFFFFFFF b=1 (WIDTH=32) -> resp result 1; XOR a=b=0xA5A5A5A5 -> result 0, zero flag 1.
